// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline control for the six-stage MIPS core
//               (PC, IF, ID, EX, MEM, ALIGN).
//               - Merges the ID/EX/MEM stall requests into a per-stage hold
//                 vector.
//               - Sequences exception and ERET redirection:
//                 IDLE -> FLUSH -> HOLD -> IDLE.
//               Optional feature macro: PIPE_CTRL_WDOG_EN. It adds a
//               stall-request watchdog with a sticky timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int unsigned WDOG_LIMIT = 1023,
  parameter int unsigned WDOG_W     = 16
) (
  input  logic        clk,
  input  logic        rst,            // asynchronous, active-low
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] except_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o,
  output logic        wdog_timeout_o
);

  localparam logic [31:0] ERET_CODE = 32'h0000_000E;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state;

  // An exception is only taken from IDLE. In FLUSH and HOLD the word at
  // ALIGN is already a flushed bubble, so it is ignored there.
  logic exc_take;
  assign exc_take = (state == IDLE) && (except_i != 32'd0);

  // Configuration parameters are folded here so that a build without the
  // watchdog still references them.
  logic unused_cfg;
  assign unused_cfg = ^{WDOG_LIMIT, WDOG_W};

  // Stall merge: the most downstream requester wins and holds every stage
  // upstream of it. Requests are dropped while a redirect is in flight, and
  // also in the cycle an exception is accepted.
  always_comb begin
    stall_o = 6'b000000;
    if ((state == IDLE) && !exc_take) begin
      if (stallreq_mem) begin
        stall_o = 6'b011111;
      end else if (stallreq_ex) begin
        stall_o = 6'b001111;
      end else if (stallreq_id) begin
        stall_o = 6'b000111;
      end
    end
  end

  // Redirect sequencer with registered flush/new_pc/busy outputs.
  // flush_o is a single-cycle pulse in FLUSH. HOLD gives the fetch of
  // new_pc one cycle before the next exception may be accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      flush_o  <= 1'b0;
      new_pc_o <= 32'd0;
      busy_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          flush_o <= 1'b0;
          busy_o  <= 1'b0;
          if (exc_take) begin
            state   <= FLUSH;
            flush_o <= 1'b1;
            busy_o  <= 1'b1;
            if (except_i == ERET_CODE) begin
              new_pc_o <= cp0_epc_i;
            end else begin
              new_pc_o <= EXC_VECTOR;
            end
          end
        end
        FLUSH: begin
          state   <= HOLD;
          flush_o <= 1'b0;
          busy_o  <= 1'b1;
        end
        HOLD: begin
          state   <= IDLE;
          flush_o <= 1'b0;
          busy_o  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          flush_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_WDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT);

  logic              any_req;
  logic              wdog_counting;
  logic [WDOG_W-1:0] wdog_cnt;
  logic [WDOG_W-1:0] wdog_next;

  assign any_req       = stallreq_id | stallreq_ex | stallreq_mem;
  assign wdog_counting = (state == IDLE) && !exc_take && any_req;

  // Next watchdog count. It saturates at the limit, and it clears on any
  // cycle that is not a live IDLE stall request.
  always_comb begin
    wdog_next = '0;
    if (wdog_counting) begin
      if (wdog_cnt == WDOG_MAX) begin
        wdog_next = wdog_cnt;
      end else begin
        wdog_next = wdog_cnt + 1'b1;
      end
    end
  end

  // The watchdog counter and the sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt       <= '0;
      wdog_timeout_o <= 1'b0;
    end else begin
      wdog_cnt <= wdog_next;
      if (wdog_counting && (wdog_next == WDOG_MAX)) begin
        wdog_timeout_o <= 1'b1;
      end
    end
  end
`else
  assign wdog_timeout_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Scoreboard testbench for pipe_ctrl. For each cycle, the
//               expected outputs come from a behavioural model of the control
//               unit. They are pushed when inputs are applied, then popped and
//               compared shortly after.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam logic [31:0] VEC  = 32'hBFC00380;
  localparam logic [31:0] ERET = 32'h0000000E;
  localparam int          LIM  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_id = 1'b0;
  logic        stallreq_ex = 1'b0;
  logic        stallreq_mem = 1'b0;
  logic [31:0] except_i = 32'd0;
  logic [31:0] cp0_epc_i = 32'd0;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;
  logic        wdog_timeout_o;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .EXC_VECTOR(VEC),
    .WDOG_LIMIT(LIM),
    .WDOG_W    (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .except_i      (except_i),
    .cp0_epc_i     (cp0_epc_i),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .new_pc_o      (new_pc_o),
    .busy_o        (busy_o),
    .wdog_timeout_o(wdog_timeout_o)
  );

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        busy;
    logic        wdog;
  } exp_t;

  typedef struct packed {
    logic        r;
    logic [2:0]  req;   // {mem, ex, id}
    logic [31:0] exc;
    logic [31:0] epc;
  } step_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model state: 0 = IDLE, 1 = FLUSH, 2 = HOLD.
  int          m_state = 0;
  logic [31:0] m_pc    = 32'd0;
  int          m_cnt   = 0;
  logic        m_to    = 1'b0;

  task automatic model_reset();
    m_state = 0;
    m_pc    = 32'd0;
    m_cnt   = 0;
    m_to    = 1'b0;
  endtask

  function automatic logic [5:0] prio(input logic [2:0] req);
    if (req[2])      return 6'b011111;
    else if (req[1]) return 6'b001111;
    else if (req[0]) return 6'b000111;
    else             return 6'b000000;
  endfunction

  // Drive one cycle of stimulus after the falling edge and queue the outputs
  // the model predicts for it.
  task automatic apply(input step_t s);
    exp_t e;
    @(negedge clk);
    rst = s.r;
    {stallreq_mem, stallreq_ex, stallreq_id} = s.req;
    except_i  = s.exc;
    cp0_epc_i = s.epc;
    if (!s.r) model_reset();
    e.stall = ((m_state == 0) && (s.exc == 32'd0)) ? prio(s.req) : 6'b000000;
    e.flush = (m_state == 1);
    e.pc    = m_pc;
    e.busy  = (m_state != 0);
    e.wdog  = m_to;
    sb.push_back(e);
  endtask

  // Advance the model across the coming rising edge, using the inputs being
  // driven now.
  task automatic model_tick();
    logic counting;
    if (!rst) return;
    counting = (m_state == 0) && (except_i == 32'd0) &&
               (stallreq_id || stallreq_ex || stallreq_mem);
    case (m_state)
      0: if (except_i != 32'd0) begin
           m_state = 1;
           m_pc    = (except_i == ERET) ? cp0_epc_i : VEC;
         end
      1: m_state = 2;
      default: m_state = 0;
    endcase
`ifdef PIPE_CTRL_WDOG_EN
    if (counting) begin
      if (m_cnt < LIM) m_cnt = m_cnt + 1;
      if (m_cnt == LIM) m_to = 1'b1;
    end else begin
      m_cnt = 0;
    end
`else
    if (counting) m_cnt = 0;
`endif
  endtask

  task automatic test_reset();
    step_t s[4];
    exp_t  e;
    s = '{'{1'b0, 3'b000, 32'd0, 32'd0}, '{1'b0, 3'b000, 32'd0, 32'd0},
          '{1'b1, 3'b000, 32'd0, 32'd0}, '{1'b1, 3'b000, 32'd0, 32'd0}};
    for (int i = 0; i < 4; i++) begin
      apply(s[i]);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if ({stall_o, flush_o, new_pc_o, busy_o, wdog_timeout_o} !== e) begin
        n_fail++;
        $display("FAIL reset[%0d]: got stall=%b flush=%b pc=%h busy=%b wdog=%b, want stall=%b flush=%b pc=%h busy=%b wdog=%b",
                 i, stall_o, flush_o, new_pc_o, busy_o, wdog_timeout_o, e.stall, e.flush, e.pc, e.busy, e.wdog);
      end
      model_tick();
    end
  endtask

  task automatic test_stall_merge();
    step_t s[7];
    exp_t  e;
    s = '{'{1'b1, 3'b011, 32'd0, 32'd0}, '{1'b1, 3'b001, 32'd0, 32'd0},
          '{1'b1, 3'b100, 32'd0, 32'd0}, '{1'b1, 3'b111, 32'd0, 32'd0},
          '{1'b1, 3'b010, 32'd0, 32'd0}, '{1'b1, 3'b101, 32'd0, 32'd0},
          '{1'b1, 3'b000, 32'd0, 32'd0}};
    for (int i = 0; i < 7; i++) begin
      apply(s[i]);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if ({stall_o, flush_o, new_pc_o, busy_o, wdog_timeout_o} !== e) begin
        n_fail++;
        $display("FAIL stall_merge[%0d]: got stall=%b flush=%b pc=%h busy=%b wdog=%b, want stall=%b flush=%b pc=%h busy=%b wdog=%b",
                 i, stall_o, flush_o, new_pc_o, busy_o, wdog_timeout_o, e.stall, e.flush, e.pc, e.busy, e.wdog);
      end
      model_tick();
    end
    // Dropping a request takes effect in the same cycle, with no edge between.
    stallreq_id = 1'b1;
    stallreq_ex = 1'b1;
    #1;
    n_cmp++;
    if (stall_o !== 6'b001111) begin
      n_fail++;
      $display("FAIL stall_same_cycle_a: got %b want %b", stall_o, 6'b001111);
    end
    stallreq_ex = 1'b0;
    #1;
    n_cmp++;
    if (stall_o !== 6'b000111) begin
      n_fail++;
      $display("FAIL stall_same_cycle_b: got %b want %b", stall_o, 6'b000111);
    end
    stallreq_id = 1'b0;
  endtask

  task automatic test_exception();
    step_t s[6];
    exp_t  e;
    s = '{'{1'b1, 3'b100, 32'd0, 32'd0}, '{1'b1, 3'b100, 32'h8, 32'h1},
          '{1'b1, 3'b100, 32'd0, 32'd0}, '{1'b1, 3'b100, 32'd0, 32'd0},
          '{1'b1, 3'b100, 32'd0, 32'd0}, '{1'b1, 3'b000, 32'd0, 32'd0}};
    for (int i = 0; i < 6; i++) begin
      apply(s[i]);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if ({stall_o, flush_o, new_pc_o, busy_o, wdog_timeout_o} !== e) begin
        n_fail++;
        $display("FAIL exception[%0d]: got stall=%b flush=%b pc=%h busy=%b wdog=%b, want stall=%b flush=%b pc=%h busy=%b wdog=%b",
                 i, stall_o, flush_o, new_pc_o, busy_o, wdog_timeout_o, e.stall, e.flush, e.pc, e.busy, e.wdog);
      end
      model_tick();
    end
  endtask

  task automatic test_eret();
    step_t s[6];
    exp_t  e;
    s = '{'{1'b1, 3'b000, ERET, 32'h80001234}, '{1'b1, 3'b000, 32'd0, 32'h0},
          '{1'b1, 3'b001, 32'h8, 32'h0},       '{1'b1, 3'b000, 32'd0, 32'h0},
          '{1'b1, 3'b000, 32'd0, 32'h0},       '{1'b1, 3'b010, 32'd0, 32'h0}};
    for (int i = 0; i < 6; i++) begin
      apply(s[i]);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if ({stall_o, flush_o, new_pc_o, busy_o, wdog_timeout_o} !== e) begin
        n_fail++;
        $display("FAIL eret[%0d]: got stall=%b flush=%b pc=%h busy=%b wdog=%b, want stall=%b flush=%b pc=%h busy=%b wdog=%b",
                 i, stall_o, flush_o, new_pc_o, busy_o, wdog_timeout_o, e.stall, e.flush, e.pc, e.busy, e.wdog);
      end
      model_tick();
    end
  endtask

  task automatic test_reset_mid_flush();
    step_t s[6];
    exp_t  e;
    s = '{'{1'b1, 3'b000, 32'h8, 32'd0}, '{1'b0, 3'b000, 32'd0, 32'd0},
          '{1'b0, 3'b000, 32'd0, 32'd0}, '{1'b1, 3'b000, 32'd0, 32'd0},
          '{1'b1, 3'b001, 32'd0, 32'd0}, '{1'b1, 3'b000, 32'd0, 32'd0}};
    for (int i = 0; i < 6; i++) begin
      apply(s[i]);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if ({stall_o, flush_o, new_pc_o, busy_o, wdog_timeout_o} !== e) begin
        n_fail++;
        $display("FAIL reset_mid_flush[%0d]: got stall=%b flush=%b pc=%h busy=%b wdog=%b, want stall=%b flush=%b pc=%h busy=%b wdog=%b",
                 i, stall_o, flush_o, new_pc_o, busy_o, wdog_timeout_o, e.stall, e.flush, e.pc, e.busy, e.wdog);
      end
      model_tick();
    end
  endtask

  task automatic test_back_to_back();
    step_t s[9];
    exp_t  e;
    s = '{'{1'b1, 3'b000, 32'h20, 32'h0},        '{1'b1, 3'b010, 32'h20, 32'h0},
          '{1'b1, 3'b000, 32'h20, 32'h0},        '{1'b1, 3'b100, ERET, 32'h80004000},
          '{1'b1, 3'b000, ERET, 32'h80004000},   '{1'b1, 3'b000, ERET, 32'h0},
          '{1'b1, 3'b000, 32'd0, 32'h0},         '{1'b1, 3'b000, 32'h4, 32'h0},
          '{1'b1, 3'b000, 32'd0, 32'h0}};
    for (int i = 0; i < 9; i++) begin
      apply(s[i]);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if ({stall_o, flush_o, new_pc_o, busy_o, wdog_timeout_o} !== e) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got stall=%b flush=%b pc=%h busy=%b wdog=%b, want stall=%b flush=%b pc=%h busy=%b wdog=%b",
                 i, stall_o, flush_o, new_pc_o, busy_o, wdog_timeout_o, e.stall, e.flush, e.pc, e.busy, e.wdog);
      end
      model_tick();
    end
  endtask

  task automatic test_watchdog();
    step_t s;
    exp_t  e;
    // Phase 0: one reset cycle, eight stall-request cycles, then four idle
    // cycles.
    // Phase 1: one reset cycle, 7 request cycles, a one-cycle gap, 7 request
    // cycles, then two idle cycles.
    for (int ph = 0; ph < 2; ph++) begin
      int n = (ph == 0) ? 13 : 18;
      for (int i = 0; i < n; i++) begin
        s.r   = (i != 0);
        s.exc = 32'd0;
        s.epc = 32'd0;
        if (ph == 0) s.req = (i >= 1 && i <= 8) ? 3'b010 : 3'b000;
        else         s.req = ((i >= 1 && i <= 7) || (i >= 9 && i <= 15)) ? 3'b010 : 3'b000;
        apply(s);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if ({stall_o, flush_o, new_pc_o, busy_o, wdog_timeout_o} !== e) begin
          n_fail++;
          $display("FAIL watchdog%0d[%0d]: got stall=%b flush=%b pc=%h busy=%b wdog=%b, want stall=%b flush=%b pc=%h busy=%b wdog=%b",
                   ph, i, stall_o, flush_o, new_pc_o, busy_o, wdog_timeout_o, e.stall, e.flush, e.pc, e.busy, e.wdog);
        end
        model_tick();
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stall_merge();
    test_exception();
    test_eret();
    test_reset_mid_flush();
    test_back_to_back();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
